// File: rtl/tomasula_types.sv
// Shared Tomasulo core types: load/store opcodes and the CDB data word.
// Pure declarations; no logic, no latency, no flow control.
package tomasula_types;

    typedef enum logic [2:0] {
        OP_LB,
        OP_LH,
        OP_LW,
        OP_LBU,
        OP_LHU,
        OP_SB,
        OP_SH,
        OP_SW
    } op_t;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/load_formatter.sv
// Selects the addressed byte/half of a memory word and sign/zero-extends it.
// Purely combinational (0 cycles); no flow control.
module load_formatter
    import tomasula_types::*;
(
    input  op_t        op,
    input  logic [1:0] offset,
    input  word_t      rdata,
    output word_t      data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data = {24'd0, byte_sel};
            OP_LH:   data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_adapter.sv
// Bridges the LSQ head to the data memory and broadcasts load results on the CDB.
// Strobes held until dmem_resp (memory-paced); lsq_resp same cycle as resp, CDB one cycle later.
module dmem_adapter
    import tomasula_types::*;
#(
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lsq_read,
    input  logic             lsq_write,
    input  logic [31:0]      lsq_addr,
    input  logic [3:0]       lsq_mbe,
    input  op_t              lsq_op,
    input  logic [TAG_W-1:0] lsq_tag,
    input  logic [31:0]      store_data,
    input  logic             flush,
    output logic             lsq_resp,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output word_t            cdb_data,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    output logic [3:0]       dmem_mbe,
    input  logic [31:0]      dmem_rdata,
    input  logic             dmem_resp
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM,
        ST_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    op_t              op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [3:0]       mbe_q, mbe_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             write_q, write_d;
    logic             cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
    word_t            cdb_data_q, cdb_data_d;
    logic             resp_c;
    logic             active;
    word_t            load_word;

    load_formatter u_fmt (
        .op     (op_q),
        .offset (addr_q[1:0]),
        .rdata  (dmem_rdata),
        .data   (load_word)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        op_d        = op_q;
        tag_d       = tag_q;
        mbe_d       = mbe_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        resp_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((lsq_read | lsq_write) & ~flush) begin
                    addr_d  = lsq_addr;
                    op_d    = lsq_op;
                    tag_d   = lsq_tag;
                    mbe_d   = lsq_mbe;
                    wdata_d = store_data << {lsq_addr[1:0], 3'b000};
                    write_d = lsq_write;
                    state_d = ST_MEM;
                end
            end
            ST_MEM: begin
                if (dmem_resp) begin
                    resp_c  = 1'b1;
                    state_d = ST_IDLE;
                    // A flush coinciding with the response retires the access silently.
                    if (!flush) begin
                        cdb_valid_d = 1'b1;
                        cdb_tag_d   = tag_q;
                        cdb_data_d  = write_q ? '0 : load_word;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (dmem_resp) begin
                    resp_c  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            op_q        <= OP_LB;
            tag_q       <= '0;
            mbe_q       <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            tag_q       <= tag_d;
            mbe_q       <= mbe_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
        end
    end

    // Outputs are forced low combinationally so a reset drops an access in its own cycle.
    assign active     = (state_q != ST_IDLE) & ~rst;
    assign dmem_read  = active & ~write_q;
    assign dmem_write = active & write_q;
    assign dmem_addr  = rst ? '0 : {addr_q[31:2], 2'b00};
    assign dmem_wdata = rst ? '0 : wdata_q;
    assign dmem_mbe   = rst ? '0 : mbe_q;
    assign lsq_resp   = resp_c & ~rst;
    assign cdb_valid  = cdb_valid_q & ~rst;
    assign cdb_tag    = rst ? '0 : cdb_tag_q;
    assign cdb_data   = rst ? '0 : cdb_data_q;

endmodule

// File: tb/tb_dmem_adapter.sv
// Self-checking bench for dmem_adapter: directed vector table, hand-written
// reset/flush/back-to-back sequences, and randomized accesses against a reference model.
module tb_dmem_adapter;
    import tomasula_types::*;

    localparam int TAG_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             lsq_read, lsq_write, flush;
    logic [31:0]      lsq_addr, store_data;
    logic [3:0]       lsq_mbe;
    op_t              lsq_op;
    logic [TAG_W-1:0] lsq_tag;
    logic             lsq_resp, cdb_valid, dmem_read, dmem_write, dmem_resp;
    logic [TAG_W-1:0] cdb_tag;
    word_t            cdb_data;
    logic [31:0]      dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]       dmem_mbe;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_adapter #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .lsq_read   (lsq_read),
        .lsq_write  (lsq_write),
        .lsq_addr   (lsq_addr),
        .lsq_mbe    (lsq_mbe),
        .lsq_op     (lsq_op),
        .lsq_tag    (lsq_tag),
        .store_data (store_data),
        .flush      (flush),
        .lsq_resp   (lsq_resp),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .dmem_read  (dmem_read),
        .dmem_write (dmem_write),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_mbe   (dmem_mbe),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp)
    );

    typedef struct {
        op_t         op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [3:0]  mbe;
        logic [2:0]  tag;
        int          lat;
        int          flush_cyc;
        logic        exp_cdb;
        logic [31:0] exp_data;
        logic [31:0] exp_wdata;
    } vec_t;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    function automatic logic is_st(input op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [31:0] ref_load(input op_t op, input logic [1:0] off, input logic [31:0] rdata);
        int          o;
        logic [31:0] b, h;
        o = int'(off);
        b = (rdata >> (8 * o)) & 32'h0000_00FF;
        h = (rdata >> (16 * (o / 2))) & 32'h0000_FFFF;
        case (op)
            OP_LB:   return (b >= 32'd128) ? b - 32'd256 : b;
            OP_LBU:  return b;
            OP_LH:   return (h >= 32'd32768) ? h - 32'd65536 : h;
            OP_LHU:  return h;
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] ref_mbe(input op_t op, input logic [1:0] off);
        case (op)
            OP_SB:   return 4'b0001 << off;
            OP_SH:   return off[1] ? 4'b1100 : 4'b0011;
            OP_SW:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check_all_zero(input string tagn);
        chk1({tagn, "_lsq_resp"}, lsq_resp, 1'b0);
        chk1({tagn, "_cdb_valid"}, cdb_valid, 1'b0);
        chk1({tagn, "_dmem_read"}, dmem_read, 1'b0);
        chk1({tagn, "_dmem_write"}, dmem_write, 1'b0);
        chk32({tagn, "_cdb_tag"}, 32'(cdb_tag), 32'd0);
        chk32({tagn, "_cdb_data"}, cdb_data, 32'd0);
        chk32({tagn, "_dmem_addr"}, dmem_addr, 32'd0);
        chk32({tagn, "_dmem_wdata"}, dmem_wdata, 32'd0);
        chk32({tagn, "_dmem_mbe"}, 32'(dmem_mbe), 32'd0);
    endtask

    task automatic run_access(input vec_t v);
        logic st;
        st = is_st(v.op);
        @(negedge clk);
        lsq_read   = !st;
        lsq_write  = st;
        lsq_addr   = v.addr;
        lsq_mbe    = v.mbe;
        lsq_op     = v.op;
        lsq_tag    = v.tag;
        store_data = v.sdata;
        flush      = 1'b0;
        dmem_resp  = 1'b0;
        #1;
        chk1("idle_read", dmem_read, 1'b0);
        chk1("idle_write", dmem_write, 1'b0);
        chk1("cdb_single_pulse", cdb_valid, 1'b0);
        for (int c = 1; c <= v.lat; c++) begin
            @(negedge clk);
            flush      = (c == v.flush_cyc);
            dmem_resp  = (c == v.lat);
            dmem_rdata = (c == v.lat) ? v.rdata : $urandom;
            #1;
            chk1("mem_read_strobe", dmem_read, !st);
            chk1("mem_write_strobe", dmem_write, st);
            chk32("mem_addr", dmem_addr, {v.addr[31:2], 2'b00});
            if (st) begin
                chk32("mem_wdata", dmem_wdata, v.exp_wdata);
                chk32("mem_mbe", 32'(dmem_mbe), 32'(v.mbe));
            end
            chk1("lsq_resp", lsq_resp, c == v.lat);
            chk1("cdb_early", cdb_valid, 1'b0);
        end
        @(negedge clk);
        lsq_read  = 1'b0;
        lsq_write = 1'b0;
        flush     = 1'b0;
        dmem_resp = 1'b0;
        #1;
        chk1("strobe_released", dmem_read | dmem_write, 1'b0);
        chk1("lsq_resp_single", lsq_resp, 1'b0);
        chk1("cdb_valid", cdb_valid, v.exp_cdb);
        if (v.exp_cdb) begin
            chk32("cdb_tag", 32'(cdb_tag), 32'(v.tag));
            chk32("cdb_data", cdb_data, v.exp_data);
        end
    endtask

    vec_t tbl[10];
    vec_t bq[$];
    logic [2:0]  etag[$];
    logic [31:0] edata[$];

    initial begin
        vec_t rv;
        int   caps, resps, cdbs, busy;
        logic pop_pend;

        rst = 1'b1; lsq_read = 1'b0; lsq_write = 1'b0; flush = 1'b0;
        lsq_addr = '0; store_data = '0; lsq_mbe = '0; lsq_op = OP_LW; lsq_tag = '0;
        dmem_rdata = '0; dmem_resp = 1'b0;

        tbl[0] = '{OP_LW,  32'h100, 32'h0,        32'hDEADBEEF, 4'b0000, 3'd5, 3, 0, 1'b1, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{OP_LB,  32'h103, 32'h0,        32'h80FF0000, 4'b0000, 3'd1, 1, 0, 1'b1, 32'hFFFFFF80, 32'h0};
        tbl[2] = '{OP_LBU, 32'h103, 32'h0,        32'h80FF0000, 4'b0000, 3'd2, 2, 0, 1'b1, 32'h00000080, 32'h0};
        tbl[3] = '{OP_SH,  32'h102, 32'h1234ABCD, 32'h55555555, 4'b1100, 3'd3, 2, 0, 1'b1, 32'h0,        32'hABCD0000};
        tbl[4] = '{OP_LW,  32'h104, 32'h0,        32'h01234567, 4'b0000, 3'd4, 3, 1, 1'b0, 32'h0,        32'h0};
        tbl[5] = '{OP_LH,  32'h102, 32'h0,        32'h80010000, 4'b0000, 3'd6, 1, 0, 1'b1, 32'hFFFF8001, 32'h0};
        tbl[6] = '{OP_LHU, 32'h101, 32'h0,        32'h80017FFE, 4'b0000, 3'd7, 2, 0, 1'b1, 32'h00007FFE, 32'h0};
        tbl[7] = '{OP_LW,  32'h108, 32'h0,        32'hA5A5A5A5, 4'b0000, 3'd0, 2, 2, 1'b0, 32'h0,        32'h0};
        tbl[8] = '{OP_SB,  32'h101, 32'h000000AB, 32'h0,        4'b0010, 3'd1, 1, 0, 1'b1, 32'h0,        32'h0000AB00};
        tbl[9] = '{OP_SW,  32'h200, 32'h11223344, 32'h0,        4'b1111, 3'd2, 4, 2, 1'b0, 32'h0,        32'h11223344};

        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) run_access(tbl[i]);

        // Flush while idle: the request must not be captured.
        @(negedge clk);
        lsq_read = 1'b1; lsq_op = OP_LW; lsq_addr = 32'h500; lsq_tag = 3'd3; flush = 1'b1;
        @(negedge clk);
        lsq_read = 1'b0; flush = 1'b0;
        #1;
        chk1("idle_flush_no_capture", dmem_read, 1'b0);

        // Reset during MEM followed by a stray response.
        @(negedge clk);
        lsq_read = 1'b1; lsq_op = OP_LW; lsq_addr = 32'h300; lsq_tag = 3'd3;
        @(negedge clk);
        #1;
        chk1("pre_reset_read", dmem_read, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0; lsq_read = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        #1;
        chk1("stray_resp_lsq_resp", lsq_resp, 1'b0);
        chk1("stray_resp_read", dmem_read, 1'b0);
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        check_all_zero("after_stray");

        // Two queued loads with lsq_read held continuously.
        bq.push_back('{OP_LW,  32'h400, 32'h0, 32'hCAFEF00D, 4'b0000, 3'd2, 2, 0, 1'b1, 32'h0, 32'h0});
        bq.push_back('{OP_LBU, 32'h401, 32'h0, 32'h0000A500, 4'b0000, 3'd6, 2, 0, 1'b1, 32'h0, 32'h0});
        caps = 0; resps = 0; cdbs = 0; busy = 0; pop_pend = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (pop_pend) begin
                void'(bq.pop_front());
                pop_pend = 1'b0;
            end
            dmem_resp = 1'b0;
            if (bq.size() > 0) begin
                lsq_read = 1'b1; lsq_op = bq[0].op; lsq_addr = bq[0].addr; lsq_tag = bq[0].tag;
            end else begin
                lsq_read = 1'b0;
            end
            if (dmem_read && bq.size() > 0) begin
                busy++;
                if (busy == 1) caps++;
                if (busy == 2) begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = bq[0].rdata;
                end
            end
            #1;
            if (lsq_resp && bq.size() > 0) begin
                resps++;
                pop_pend = 1'b1;
                busy = 0;
                etag.push_back(bq[0].tag);
                edata.push_back(ref_load(bq[0].op, bq[0].addr[1:0], bq[0].rdata));
            end
            if (cdb_valid) begin
                cdbs++;
                if (etag.size() > 0) begin
                    chk32("b2b_cdb_tag", 32'(cdb_tag), 32'(etag.pop_front()));
                    chk32("b2b_cdb_data", cdb_data, edata.pop_front());
                end
            end
        end
        lsq_read = 1'b0;
        chk32("b2b_captures", 32'(caps), 32'd2);
        chk32("b2b_lsq_resps", 32'(resps), 32'd2);
        chk32("b2b_cdb_count", 32'(cdbs), 32'd2);

        // Randomized accesses against the reference model.
        for (int n = 0; n < 40; n++) begin
            rv.op        = op_t'($urandom_range(0, 7));
            rv.addr      = $urandom;
            rv.sdata     = $urandom;
            rv.rdata     = $urandom;
            rv.tag       = 3'($urandom_range(0, 7));
            rv.lat       = $urandom_range(1, 4);
            rv.flush_cyc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rv.lat) : 0;
            rv.mbe       = ref_mbe(rv.op, rv.addr[1:0]);
            rv.exp_cdb   = (rv.flush_cyc == 0);
            rv.exp_data  = is_st(rv.op) ? 32'h0 : ref_load(rv.op, rv.addr[1:0], rv.rdata);
            rv.exp_wdata = rv.sdata << (8 * int'(rv.addr[1:0]));
            run_access(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_adapter.md
DMEM_ADAPTER -- requirements
Module: dmem_adapter

Interface
REQ-001 Parameter: TAG_W, default 3, ROB tag width.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 lsq_read  input  1  load request from LSQ head, held until lsq_resp.
REQ-005 lsq_write  input  1  store request from LSQ head, held until lsq_resp.
REQ-006 lsq_addr  input  32  byte address of access.
REQ-007 lsq_mbe  input  4  store byte enables, already shifted by address offset.
REQ-008 lsq_op  input  tomasula_types::op_t  load/store type (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-009 lsq_tag  input  TAG_W  ROB tag of the access.
REQ-010 store_data  input  32  unshifted store source register value.
REQ-011 flush  input  1  pipeline flush in progress.
REQ-012 lsq_resp  output  1  one-cycle pulse: access retired; LSQ advances head.
REQ-013 cdb_valid / cdb_tag / cdb_data  output  1 / TAG_W / 32  registered CDB broadcast.
REQ-014 dmem_read / dmem_write  output  1 / 1  memory request strobes.
REQ-015 dmem_addr / dmem_wdata / dmem_mbe  output  32 / 32 / 4  word-aligned address, lane-shifted data, byte enables.
REQ-016 dmem_rdata / dmem_resp  input  32 / 1  memory read word and completion pulse.

Function
REQ-017 FSM states: IDLE, MEM, DRAIN.
REQ-018 IDLE: on (lsq_read | lsq_write) & ~flush, latch addr, op, tag, mbe, and store_data << 8*addr[1:0]; next state MEM.
REQ-019 IDLE with flush asserted: no capture, remain IDLE.
REQ-020 MEM: dmem_read or dmem_write held high, with dmem_addr = {addr[31:2],2'b00}, for every cycle until dmem_resp.
REQ-021 Request inputs are ignored while in MEM or DRAIN; no second capture until IDLE is re-entered.
REQ-022 MEM & dmem_resp & ~flush: lsq_resp = 1 in the same cycle (combinational); next state IDLE.
REQ-023 Registered result, one cycle after dmem_resp: cdb_valid = 1, cdb_tag = latched tag, cdb_data = formatted load data (stores: cdb_data = 0).
REQ-024 MEM & flush & ~dmem_resp: next state DRAIN; memory strobes stay asserted.
REQ-025 MEM & flush & dmem_resp: lsq_resp = 1, no CDB broadcast; next state IDLE.
REQ-026 DRAIN: strobes held until dmem_resp; then lsq_resp = 1, no CDB broadcast, next state IDLE.
REQ-027 Load formatting, off = addr[1:0]:
- LB/LBU: byte rdata[8*off+:8], sign-extended or zero-extended.
- LH/LHU: half rdata[16*off[1]+:16], sign-extended or zero-extended; off[0] ignored.
- LW: rdata unmodified.
REQ-028 Minimum request-to-request spacing is 2 cycles: capture, then MEM; back-to-back LSQ heads are accepted on the cycle after lsq_resp.
REQ-029 cdb_valid is a single-cycle pulse per completed non-flushed access.

Reset
REQ-030 While rst is high: state IDLE; lsq_resp, cdb_valid, dmem_read, dmem_write = 0; cdb_tag, cdb_data, dmem_addr, dmem_wdata, dmem_mbe = 0.
REQ-031 Reset mid-access drops the request immediately; a dmem_resp arriving after reset is ignored.

Structure
REQ-032 op_t and cdb_data types come from the shared tomasula_types package; the FSM state enum is local to the module.
REQ-033 Load extraction/extension is a combinational sub-module load_formatter (inputs op, offset, rdata; output 32-bit word).

Verification
REQ-034 LW at 0x100, tag 5, rdata 0xDEADBEEF, resp after 3 cycles -> dmem_read high 3 cycles; lsq_resp pulse; next cycle cdb_valid, tag 5, data 0xDEADBEEF.
REQ-035 LB at 0x103 and LBU at 0x103, rdata 0x80FF0000 -> cdb_data 0xFFFFFF80 and 0x00000080 respectively.
REQ-036 SH at 0x102, store_data 0x1234ABCD, mbe 1100 -> dmem_wdata 0xABCD0000, dmem_mbe 1100, dmem_write until resp; cdb_data 0.
REQ-037 Flush asserted 1 cycle into LW, resp 2 cycles later -> state DRAIN; strobe held; lsq_resp on resp; no cdb_valid.
REQ-038 rst asserted during MEM, then a stray dmem_resp -> all outputs 0, no lsq_resp, no cdb_valid.
REQ-039 Two queued loads, lsq_read held continuously -> exactly two captures, two lsq_resp pulses, two CDB broadcasts in order.
